pipemulctl: RTL and testbench
=============================

# pipemulctl

Multi-cycle multiply sequencer and register-file write-port arbiter for the five-stage pipeline. It takes `mul`/`muli` operands issued from EXE and runs an iterative shift-add multiply off the main pipe. It stalls ID on structural, RAW and WAW conflicts with the in-flight destination, and arbitrates the single WB write port against the main pipeline.

## Interface
- `WIDTH`, 32: operand and result width.
- `STEP`, 1: multiplier bits retired per RUN cycle; legal values 1, 2, 4; `N = WIDTH/STEP` iterations.

- `clock  in  1`: sole clock; all state changes on rising edge.
- `reset  in  1`: asynchronous, active-high; returns the block to IDLE immediately.
- `start  in  1`: EXE holds a valid mul/muli this cycle.
- `a, b  in  WIDTH`: multiplicand and multiplier, sampled with `start`.
- `ern  in  5`: destination register of the issuing mul.
- `id_mul  in  1`: ID instruction is mul/muli.
- `rs, rt  in  5`: ID source register numbers.
- `rs_isreg, rt_isreg  in  1`: ID actually reads rs/rt.
- `id_wreg  in  1`, `id_wrn  in  5`: ID instruction writes `id_wrn`.
- `mwreg  in  1`: main pipe owns the WB write port this cycle.
- `stall  out  1`: freeze PC, IF/ID; inject bubble into EXE.
- `busy  out  1`: state ≠ IDLE.
- `we  out  1`, `wrn  out  5`, `wdata  out  WIDTH`: WB write-port request; regfile mux selects these when `we`=1.

## Operation
- States: IDLE, RUN, WAIT_WB. Encoding lives in the package.
- IDLE: if `start`, latch `a`→mcand, `b`→mplier, `ern`→dest, clear acc, load count=N-1, go RUN.
- RUN: acc += (mplier[STEP-1:0] × mcand) mod 2^WIDTH; mcand <<= STEP; mplier >>= STEP; count -= 1. When count==0 on this step, go WAIT_WB.
- Result is the low WIDTH bits of the product, so signedness is irrelevant.
- WAIT_WB: `we` = ~mwreg & (dest≠0). The main pipe has priority.
  - Go IDLE on any edge where `mwreg`=0; dest==0 retires in one cycle with no write.
  - While `mwreg`=1, hold WAIT_WB; acc and dest stay stable.
- `start` outside IDLE is ignored. It cannot occur legally, since `stall` blocks it.
- `stall` = busy & (id_mul | hit(rs,rs_isreg) | hit(rt,rt_isreg) | hit(id_wrn,id_wreg)).
  - hit(r,v) = v & (r==dest) & (dest≠0).
  - `stall` is combinational; it deasserts the cycle the block is IDLE.
- Outputs: `wrn`=dest and `wdata`=acc at all times; only `we` qualifies them.
- Reset values: state IDLE, acc 0, dest 0, count 0, mcand/mplier 0. Hence `busy`=0, `stall`=0, `we`=0, `wrn`=0, `wdata`=0.
- Reset mid-RUN or mid-WAIT_WB discards the operation; no write occurs.

## Timing
- `start` at edge E0 → RUN for cycles 1..N → WAIT_WB at cycle N+1.
- Earliest `we` is cycle N+1; IDLE at N+2.
- Latency start→write = N+1 cycles, plus one per cycle of `mwreg`=1.
- WIDTH=32, STEP=1: write in cycle 33. STEP=4: write in cycle 9.
- Dependent ID instruction issues the cycle after the write. The regfile writes first-half / reads second-half, so no bypass is needed.
- `stall` is valid same cycle as ID inputs; no registered delay.

## Configuration
- `PIPEMULCTL_EARLY_OUT_EN`
  - Defined: in RUN, also exit to WAIT_WB when the post-shift mplier is 0. Minimum RUN is one cycle. Latency becomes ceil(msb(b)+1, STEP)/STEP + 1 cycles; b=0 → write in cycle 2.
  - Undefined: latency is fixed at N+1 regardless of data.

## Structure
- Package `pipemul_pkg`: state enum (IDLE=2'd0, RUN=2'd1, WAIT_WB=2'd2), default WIDTH/STEP constants, STEP legality check, count width = clog2(N).
- Sub-module `pipemul_step`: combinational STEP-bit partial-product add (acc, mcand, mplier slice → next acc).
- Top holds FSM, counter, scoreboard/stall compare and write-port arbitration.

## Test plan
- Reset then a=7, b=6, ern=5, STEP=1, mwreg=0 → busy 1..33; we=1, wrn=5, wdata=42 in cycle 33; IDLE in cycle 34.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → wdata=32'h0000_0001. a=32'h8000_0000, b=2 → wdata=0.
- mwreg=1 during cycles 33..35 → we=0 and held; we=1 in cycle 36, wdata unchanged.
- While busy with dest=5: ID rs=5 with rs_isreg=1 → stall=1. rs=5 with rs_isreg=0 → stall=0. id_wrn=5 with id_wreg=1 → stall=1. id_mul=1 → stall=1. Any case with ern=0 → no hits, we never asserts.
- Assert reset in cycle 10 of RUN → all outputs 0 immediately; no write. A new start after release completes normally.
- EARLY_OUT defined: b=0 → we in cycle 2; b=3, STEP=1 → we in cycle 3. Undefined: both in cycle 33.

Source files
------------

// File: rtl/pipemul_pkg.sv
// Shared types and constants for the multi-cycle multiply sequencer.
package pipemul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WAIT_WB = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 32;
    localparam int STEP_DEF  = 1;

    function automatic bit step_legal(input int step);
        return (step == 1) || (step == 2) || (step == 4);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A zero destination never carries a real dependency.
    function automatic logic reg_hit(input logic [4:0] r, input logic v, input logic [4:0] dest);
        return v & (r == dest) & (dest != 5'd0);
    endfunction

endpackage

// File: rtl/pipemul_step.sv
// One STEP-bit shift-add iteration: acc + digit * mcand, truncated to WIDTH.
module pipemul_step
    import pipemul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [STEP-1:0]  digit,
    output logic [WIDTH-1:0] acc_nxt
);

    logic [STEP-1:0][WIDTH-1:0] pp;

    for (genvar i = 0; i < STEP; i++) begin : g_pp
        assign pp[i] = digit[i] ? (mcand << i) : '0;
    end

    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < STEP; i++) begin
            acc_nxt = acc_nxt + pp[i];
        end
    end

endmodule

// File: rtl/pipemulctl.sv
// Iterative multiply sequencer with ID hazard stall and WB write-port arbitration.
// Optional PIPEMULCTL_EARLY_OUT_EN: leave RUN as soon as the remaining multiplier is zero.
module pipemulctl
    import pipemul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       ern,
    input  logic             id_mul,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             rs_isreg,
    input  logic             rt_isreg,
    input  logic             id_wreg,
    input  logic [4:0]       id_wrn,
    input  logic             mwreg,
    output logic             stall,
    output logic             busy,
    output logic             we,
    output logic [4:0]       wrn,
    output logic [WIDTH-1:0] wdata
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = cnt_w(N);

    if (!step_legal(STEP) || (WIDTH % STEP) != 0) begin : g_bad_step
        $error("pipemulctl: STEP must be 1, 2 or 4 and divide WIDTH");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand, mcand_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [4:0]       dest, dest_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mplier_sh;
    logic             done;

    pipemul_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc     (acc),
        .mcand   (mcand),
        .digit   (mplier[STEP-1:0]),
        .acc_nxt (acc_step)
    );

    assign mplier_sh = mplier >> STEP;

`ifdef PIPEMULCTL_EARLY_OUT_EN
    assign done = (count == '0) || (mplier_sh == '0);
`else
    assign done = (count == '0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            dest   <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            dest   <= dest_nxt;
            count  <= count_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        dest_nxt   = dest;
        count_nxt  = count;
        case (state)
            IDLE: begin
                if (start) begin
                    mcand_nxt  = a;
                    mplier_nxt = b;
                    dest_nxt   = ern;
                    acc_nxt    = '0;
                    count_nxt  = CW'(N - 1);
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                acc_nxt    = acc_step;
                mcand_nxt  = mcand << STEP;
                mplier_nxt = mplier_sh;
                count_nxt  = count - CW'(1);
                if (done) state_nxt = WAIT_WB;
            end
            WAIT_WB: begin
                // Main pipe owns the port while mwreg is high; result waits.
                if (!mwreg) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign we    = (state == WAIT_WB) & ~mwreg & (dest != 5'd0);
    assign wrn   = dest;
    assign wdata = acc;
    assign stall = busy & (id_mul
                         | reg_hit(rs, rs_isreg, dest)
                         | reg_hit(rt, rt_isreg, dest)
                         | reg_hit(id_wrn, id_wreg, dest));

endmodule

// File: tb/tb_pipemulctl.sv
// Directed bench for pipemulctl (WIDTH=32, STEP=1): latency, arbitration, stall and reset.
module tb_pipemulctl;

    localparam int WIDTH = 32;
    localparam int STEP  = 1;
    localparam int N     = WIDTH / STEP;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic [4:0]       ern = '0;
    logic             id_mul = 1'b0;
    logic [4:0]       rs = '0, rt = '0;
    logic             rs_isreg = 1'b0, rt_isreg = 1'b0;
    logic             id_wreg = 1'b0;
    logic [4:0]       id_wrn = '0;
    logic             mwreg = 1'b0;
    logic             stall, busy, we;
    logic [4:0]       wrn;
    logic [WIDTH-1:0] wdata;

    int n_tests = 0;
    int n_fail  = 0;

    pipemulctl #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .ern      (ern),
        .id_mul   (id_mul),
        .rs       (rs),
        .rt       (rt),
        .rs_isreg (rs_isreg),
        .rt_isreg (rt_isreg),
        .id_wreg  (id_wreg),
        .id_wrn   (id_wrn),
        .mwreg    (mwreg),
        .stall    (stall),
        .busy     (busy),
        .we       (we),
        .wrn      (wrn),
        .wdata    (wdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ern;
        logic [31:0] exp;
        int          hold;
    } mul_vec_t;

    typedef struct {
        logic       id_mul;
        logic [4:0] rs;
        logic       rs_isreg;
        logic [4:0] rt;
        logic       rt_isreg;
        logic       id_wreg;
        logic [4:0] id_wrn;
        logic       exp;
    } stall_vec_t;

    mul_vec_t   mv[8];
    stall_vec_t sv[7];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write cycle counted from the start edge, with no mwreg holdoff.
    function automatic int exp_lat(input logic [31:0] bv);
`ifdef PIPEMULCTL_EARLY_OUT_EN
        int m;
        if (bv == 0) return 2;
        m = 0;
        for (int i = 0; i < WIDTH; i++) if (bv[i]) m = i;
        return (m + STEP) / STEP + 1;
`else
        return N + 1;
`endif
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [4:0] tern,
                         input logic [31:0] texp, input int thold);
        int lat, we_cyc, idle_cyc;
        lat = exp_lat(tb);
        we_cyc = -1;
        idle_cyc = -1;
        @(negedge clock);
        a = ta; b = tb; ern = tern; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            mwreg = (c >= lat) && (c < lat + thold);
            #1;
            if (!busy) begin
                idle_cyc = c;
                break;
            end
            if (we && we_cyc < 0) begin
                we_cyc = c;
                chk("wdata", wdata, texp);
                chk("wrn", wrn, tern);
            end
            @(negedge clock);
        end
        mwreg = 1'b0;
        chk("we_cycle", we_cyc, (tern == 0) ? -1 : lat + thold);
        chk("idle_cycle", idle_cyc, lat + thold + 1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            #1;
            if (!busy) break;
        end
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        mv[0] = '{32'd7,          32'd6,          5'd5,  32'd42,         0};
        mv[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'h0000_0001,  0};
        mv[2] = '{32'h8000_0000,  32'd2,          5'd7,  32'h0,          0};
        mv[3] = '{32'd7,          32'd6,          5'd5,  32'd42,         3};
        mv[4] = '{32'h1234,       32'd0,          5'd9,  32'h0,          0};
        mv[5] = '{32'd5,          32'd3,          5'd2,  32'd15,         0};
        mv[6] = '{32'd123,        32'd456,        5'd0,  32'd56088,      0};
        mv[7] = '{32'hDEAD_BEEF,  32'h10,         5'd31, 32'hEADB_EEF0,  0};

        sv[0] = '{1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1};
        sv[1] = '{1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0};
        sv[2] = '{1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b1};
        sv[3] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1};
        sv[4] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0};
        sv[5] = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1};
        sv[6] = '{1'b0, 5'd4, 1'b1, 5'd6, 1'b1, 1'b1, 5'd3, 1'b0};

        // Reset state
        id_mul = 1'b1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_we", we, 0);
        chk("rst_wrn", wrn, 0);
        chk("rst_wdata", wdata, 0);
        @(negedge clock);
        reset = 1'b0;
        id_mul = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(mv[i].a, mv[i].b, mv[i].ern, mv[i].exp, mv[i].hold);
        end

        // Stall compare against dest=5 while busy
        @(negedge clock);
        a = 32'd7; b = 32'd6; ern = 5'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            id_mul = sv[i].id_mul; rs = sv[i].rs; rs_isreg = sv[i].rs_isreg;
            rt = sv[i].rt; rt_isreg = sv[i].rt_isreg;
            id_wreg = sv[i].id_wreg; id_wrn = sv[i].id_wrn;
            #1;
            chk($sformatf("stall_vec%0d", i), stall, sv[i].exp);
            @(negedge clock);
        end
        id_mul = 1'b0; rs = 5'd5; rs_isreg = 1'b1;
        rt = '0; rt_isreg = 1'b0; id_wreg = 1'b0; id_wrn = '0;
        wait_idle();
        chk("stall_idle", stall, 0);

        // dest=0: register matches never stall, id_mul still does
        @(negedge clock);
        a = 32'd3; b = 32'd3; ern = 5'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        rs = 5'd0; rs_isreg = 1'b1; rt = 5'd0; rt_isreg = 1'b1; id_wreg = 1'b1; id_wrn = 5'd0;
        #1;
        chk("stall_dest0", stall, 0);
        id_mul = 1'b1;
        #1;
        chk("stall_dest0_mul", stall, 1);
        id_mul = 1'b0; rs_isreg = 1'b0; rt_isreg = 1'b0; id_wreg = 1'b0;
        wait_idle();

        // Reset mid-RUN discards the operation
        @(negedge clock);
        a = 32'd7; b = 32'd6; ern = 5'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        chk("pre_rst_busy", busy, 1);
        id_mul = 1'b1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_we", we, 0);
        chk("midrst_wrn", wrn, 0);
        chk("midrst_wdata", wdata, 0);
        @(negedge clock);
        reset = 1'b0;
        id_mul = 1'b0;
        @(negedge clock);
        #1;
        chk("postrst_busy", busy, 0);
        chk("postrst_we", we, 0);
        do_op(32'd9, 32'd9, 5'd4, 32'd81, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
